saradc_scan_ctrl: RTL
=====================

SARADC_SCAN_CTRL -- requirements
Module: saradc_scan_ctrl

Interface
REQ-001 Parameters: N, 4, SAR resolution in bits (2..16); CH, 4, analog channel count (1..16); SAMPLE_CYC, 2, sampling-phase length in clocks (1..15).
REQ-002 Ports: clk_1Mhz  in  1  single system clock, all logic on rising edge.
REQ-003 Ports: reset  in  1  asynchronous, active-low reset.
REQ-004 Ports: start  in  1  conversion request, sampled in IDLE only; scan_en  in  1  1 = scan channels 0..CH-1, 0 = single channel ch_sel; cont  in  1  auto-restart after last conversion.
REQ-005 Ports: ch_sel  in  clog2(CH) (min 1)  channel for single mode; decision  in  1  comparator output, 1 = Vin >= Vdac.
REQ-006 Ports: rd_ready  in  1  consumer accepts result; clr_ovr  in  1  clears overrun flag.
REQ-007 Ports: S2b  out  1  sample-switch control, high during SAMPLE; comp_clk  out  1  comparator strobe, high during CONV; dac_code  out  N  trial code to capacitive DAC.
REQ-008 Ports: ch_addr  out  clog2(CH)  mux channel; busy  out  1  high whenever state != IDLE.
REQ-009 Ports: result  out  N  converted code; result_ch  out  clog2(CH)  channel of result; result_valid  out  1  result held; overrun  out  1  sticky loss flag.

Function
REQ-010 FSM states IDLE, SAMPLE, CONV, DONE; all outputs registered.
REQ-011 IDLE: start=1 -> SAMPLE next cycle; ch_addr loads ch_sel (scan_en=0) or 0 (scan_en=1); scan_en latched at start.
REQ-012 SAMPLE: S2b=1, dac_code=0, lasts exactly SAMPLE_CYC cycles, then CONV.
REQ-013 CONV: exactly N cycles, bit index k from N-1 down to 0; during bit k, dac_code = accepted upper bits, bit k = 1, lower bits 0; comp_clk=1.
REQ-014 At rising edge ending bit k, bit k of code <= decision; lower bits stay 0.
REQ-015 DONE: one cycle; final code copied to result, ch_addr to result_ch, result_valid set at edge ending DONE.
REQ-016 Per-channel conversion = SAMPLE_CYC + N + 1 clocks from SAMPLE entry to result_valid high.
REQ-017 After DONE: scan mode and ch_addr < CH-1 -> ch_addr+1, SAMPLE; ch_addr = CH-1 (or single mode) -> cont=1 restarts (ch_addr 0 or ch_sel, SAMPLE), else IDLE.
REQ-018 Handshake: result_valid && rd_ready at clock edge clears result_valid; result stable while result_valid high.
REQ-019 Write in DONE while result_valid=1 and rd_ready=0: result overwritten, overrun <= 1; write with rd_ready=1 same cycle: no overrun, result_valid stays 1.
REQ-020 overrun cleared only by clr_ovr=1 or reset; simultaneous set and clr_ovr -> overrun=1 (set wins).
REQ-021 start ignored outside IDLE; cont sampled only at end of DONE; cont deasserted mid-scan finishes current scan then IDLE.
REQ-022 ch_sel >= CH in single mode: converted as channel CH-1.

Reset
REQ-023 reset=0 asynchronously forces IDLE; S2b, comp_clk, busy, result_valid, overrun = 0; dac_code, result, result_ch, ch_addr = 0.
REQ-024 reset asserted mid-CONV aborts conversion, no partial result written; operation resumes only on start after reset release.

Verification (N=4, CH=4, SAMPLE_CYC=2)
REQ-025 Single mode ch_sel=2, start pulse, decision per bit 1,0,1,1 -> dac_code 1000,1100,1010,1011; result=1011, result_ch=2, result_valid 7 clocks after SAMPLE entry; busy falls next cycle.
REQ-026 Scan mode, decision constant 1, rd_ready=1 -> four results 1111 with result_ch 0,1,2,3 every 7 clocks, then IDLE, overrun=0.
REQ-027 Scan mode, rd_ready=0 -> overrun=1 after channel 1 result, result_ch=3 at end; clr_ovr pulse -> overrun=0.
REQ-028 cont=1, single mode ch_sel=0 -> continuous results every 7 clocks, busy never drops; cont=0 -> IDLE after current DONE.
REQ-029 reset=0 during bit 2 of CONV -> all outputs zero immediately, result_valid stays 0; start after release converts normally.
REQ-030 start held high in CONV and DONE with cont=0 -> no extra conversion until return to IDLE.

Source files
------------

// File: rtl/saradc_scan_ctrl.sv
// saradc_scan_ctrl
// Successive-approximation ADC sequencer with channel scanning.
// Each conversion runs SAMPLE (SAMPLE_CYC clocks), CONV (N clocks, one per
// bit, MSB first) and DONE (1 clock). The finished code is then published
// through a result_valid / rd_ready handshake.
//
// Ports
//   clk_1Mhz      system clock, rising edge
//   reset         asynchronous, active-low
//   start         conversion request (IDLE only)
//   scan_en       1 = scan channels 0..CH-1, 0 = single channel ch_sel
//   cont          auto-restart after the last conversion of a pass
//   ch_sel        channel for single mode (values >= CH map to CH-1)
//   decision      comparator output, 1 = Vin >= Vdac
//   rd_ready      consumer accepts the held result
//   clr_ovr       clears the sticky overrun flag
//   S2b           sample switch, high during SAMPLE
//   comp_clk      comparator strobe, high during CONV
//   dac_code      trial code to the capacitive DAC
//   ch_addr       analog mux channel
//   busy          high whenever the sequencer is not IDLE
//   result        converted code
//   result_ch     channel of result
//   result_valid  result held for the consumer
//   overrun       sticky flag: an unread result was overwritten
module saradc_scan_ctrl #(
    parameter int N          = 4,
    parameter int CH         = 4,
    parameter int SAMPLE_CYC = 2,
    localparam int CW        = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic          clk_1Mhz,
    input  logic          reset,
    input  logic          start,
    input  logic          scan_en,
    input  logic          cont,
    input  logic [CW-1:0] ch_sel,
    input  logic          decision,
    input  logic          rd_ready,
    input  logic          clr_ovr,
    output logic          S2b,
    output logic          comp_clk,
    output logic [N-1:0]  dac_code,
    output logic [CW-1:0] ch_addr,
    output logic          busy,
    output logic [N-1:0]  result,
    output logic [CW-1:0] result_ch,
    output logic          result_valid,
    output logic          overrun
);

    localparam int            BW        = $clog2(N);
    localparam logic [CW-1:0] CH_LAST   = CW'(CH - 1);
    localparam logic [3:0]    SAMP_LAST = 4'(SAMPLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

    state_t        state, state_nx;
    logic [3:0]    samp_cnt;
    logic [BW-1:0] bit_idx;
    logic [N-1:0]  code;      // bits already decided, lower bits zero
    logic [N-1:0]  code_upd;  // code with the current bit's decision applied
    logic [N-1:0]  dac_nx;
    logic [CW-1:0] ch_eff;
    logic [CW-1:0] ch_nx;
    logic          scan_q;
    logic          last_ch;
    logic          ovr_set;

    // Out-of-range single-mode selections fold onto the top channel.
    always_comb begin
        ch_eff = ch_sel;
        if (int'(ch_sel) >= CH)
            ch_eff = CH_LAST;
    end

    always_comb begin
        code_upd = code | (N'(decision) << bit_idx);
        last_ch  = !scan_q || (ch_addr == CH_LAST);
        ovr_set  = (state == DONE) && result_valid && !rd_ready;
    end

    always_ff @(posedge clk_1Mhz or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        ch_nx    = ch_addr;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SAMPLE;
                    ch_nx    = scan_en ? '0 : ch_eff;
                end
            end
            SAMPLE: begin
                if (samp_cnt == SAMP_LAST)
                    state_nx = CONV;
            end
            CONV: begin
                if (bit_idx == '0)
                    state_nx = DONE;
            end
            DONE: begin
                if (!last_ch) begin
                    state_nx = SAMPLE;
                    ch_nx    = ch_addr + CW'(1);
                end else if (cont) begin
                    state_nx = SAMPLE;
                    ch_nx    = scan_q ? '0 : ch_eff;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe. While staying in CONV the next trial keeps the
    // freshly decided bit and raises the bit below it.
    always_comb begin
        dac_nx = '0;
        case (state_nx)
            CONV: begin
                if (state == CONV)
                    dac_nx = code_upd | (N'(1) << (bit_idx - BW'(1)));
                else
                    dac_nx = N'(1) << (N - 1);
            end
            DONE:    dac_nx = code_upd;
            default: dac_nx = '0;
        endcase
    end

    always_ff @(posedge clk_1Mhz or negedge reset) begin
        if (!reset) begin
            S2b          <= 1'b0;
            comp_clk     <= 1'b0;
            busy         <= 1'b0;
            dac_code     <= '0;
            ch_addr      <= '0;
            samp_cnt     <= '0;
            bit_idx      <= '0;
            code         <= '0;
            scan_q       <= 1'b0;
            result       <= '0;
            result_ch    <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            S2b      <= (state_nx == SAMPLE);
            comp_clk <= (state_nx == CONV);
            busy     <= (state_nx != IDLE);
            dac_code <= dac_nx;
            ch_addr  <= ch_nx;

            if (state == IDLE && start)
                scan_q <= scan_en;

            if (state_nx == SAMPLE && state != SAMPLE)
                samp_cnt <= '0;
            else if (state == SAMPLE)
                samp_cnt <= samp_cnt + 4'd1;

            if (state == SAMPLE) begin
                bit_idx <= BW'(N - 1);
                code    <= '0;
            end else if (state == CONV) begin
                code <= code_upd;
                if (bit_idx != '0)
                    bit_idx <= bit_idx - BW'(1);
            end

            // A write in DONE always leaves a valid result, even when the
            // consumer takes the previous one on the same edge.
            if (state == DONE) begin
                result       <= code;
                result_ch    <= ch_addr;
                result_valid <= 1'b1;
            end else if (result_valid && rd_ready) begin
                result_valid <= 1'b0;
            end

            if (ovr_set)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
        end
    end

endmodule
